// File: rtl/instr_fetch_queue.sv
// Fetch stage: drives the memory read address from the fetch PC and captures the
// returned words into a small in-order queue that is handed to decode over valid/ready.
module instr_fetch_queue #(
   parameter int          ADDR_WIDTH  = 7,
   parameter int          DATA_WIDTH  = 32,
   parameter logic [31:0] RESET_PC    = 32'h0,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] memAddress,
   input  logic [DATA_WIDTH-1:0] memData,
   input  logic                  redirect,
   input  logic [31:0]           redirectPC,
   output logic                  outValid,
   input  logic                  outReady,
   output logic [DATA_WIDTH-1:0] outInstr,
   output logic [31:0]           outPC,
   output logic [31:0]           fetchPC
);

   localparam int              PTR_W     = $clog2(QUEUE_DEPTH);
   localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W+1)'(QUEUE_DEPTH);

   logic [31:0]           fetchPCReg;
   logic [PTR_W:0]        countReg;
   logic [PTR_W-1:0]      headPtrReg;
   logic [PTR_W-1:0]      tailPtrReg;
   logic [DATA_WIDTH-1:0] instrMem [QUEUE_DEPTH];
   logic [31:0]           pcMem    [QUEUE_DEPTH];

   logic                  pop;
   logic                  push;
   logic [PTR_W:0]        countNext;
   logic                  unusedBits;

   assign unusedBits = ^redirectPC[1:0];

   always_comb begin
      pop       = 1'b0;
      push      = 1'b0;
      countNext = countReg;
      pop  = (countReg != '0) & outReady;
      push = ~redirect & ((countReg < DEPTH_CNT) | pop);
      countNext = countReg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
   end

   // Pointers and count; a redirect empties the queue but the current head
   // handshake still completes because decode has already taken it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetchPCReg <= RESET_PC;
         countReg   <= '0;
         headPtrReg <= '0;
         tailPtrReg <= '0;
      end else if (redirect) begin
         fetchPCReg <= {redirectPC[31:2], 2'b00};
         countReg   <= '0;
         headPtrReg <= '0;
         tailPtrReg <= '0;
      end else begin
         countReg <= countNext;
         if (push) begin
            fetchPCReg <= fetchPCReg + 32'd4;
            tailPtrReg <= tailPtrReg + PTR_W'(1);
         end
         if (pop)
            headPtrReg <= headPtrReg + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            instrMem[i] <= '0;
            pcMem[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (push && tailPtrReg == PTR_W'(i)) begin
               instrMem[i] <= memData;
               pcMem[i]    <= fetchPCReg;
            end
         end
      end
   end

   assign memAddress = fetchPCReg[ADDR_WIDTH+1:2];
   assign fetchPC    = fetchPCReg;
   assign outValid   = (countReg != '0);
   assign outInstr   = instrMem[headPtrReg];
   assign outPC      = pcMem[headPtrReg];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: a 128-word memory model feeds the fetch port and a
// scoreboard of expected {PC, instruction} pairs is checked at each decode handshake.
module tb_instr_fetch_queue;

   localparam int AW = 7;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] memAddress;
   logic [DW-1:0] memData;
   logic          redirect = 1'b0;
   logic [31:0]   redirectPC = 32'h0;
   logic          outValid;
   logic          outReady = 1'b1;
   logic [DW-1:0] outInstr;
   logic [31:0]   outPC;
   logic [31:0]   fetchPC;

   logic [DW-1:0] mem [0:127];
   logic [63:0]   expQ [$];
   logic [63:0]   expHead;
   int            vectors = 0;
   int            miscompares = 0;

   assign memData = mem[memAddress];

   always #5 clk = ~clk;

   instr_fetch_queue #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'h0), .QUEUE_DEPTH(2)
   ) dut (
      .clk(clk), .reset(reset), .memAddress(memAddress), .memData(memData),
      .redirect(redirect), .redirectPC(redirectPC), .outValid(outValid),
      .outReady(outReady), .outInstr(outInstr), .outPC(outPC), .fetchPC(fetchPC)
   );

   task automatic doReset(input logic ready);
      @(negedge clk);
      reset    = 1'b1;
      redirect = 1'b0;
      outReady = ready;
      @(negedge clk);
      reset = 1'b0;
      expQ.delete();
   endtask

   task automatic test_reset();
      outReady = 1'b1;
      @(negedge clk);
      vectors++;
      if (outValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", outValid); end
      vectors++;
      if (outPC !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want 0", outPC); end
      vectors++;
      if (outInstr !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h want 0", outInstr); end
      vectors++;
      if (fetchPC !== 32'h0) begin miscompares++; $display("FAIL reset_fetchpc got %h want 0", fetchPC); end
      vectors++;
      if (memAddress !== 7'd0) begin miscompares++; $display("FAIL reset_memaddr got %0d want 0", memAddress); end
      $display("reset: valid=%b pc=%h instr=%h fetchPC=%h", outValid, outPC, outInstr, fetchPC);
      reset = 1'b0;
   endtask

   task automatic test_stream();
      expQ.push_back({32'h0, 32'h11});
      expQ.push_back({32'h4, 32'h22});
      expQ.push_back({32'h8, 32'h33});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (outValid !== 1'b1 || expQ.size() == 0) begin
            miscompares++; $display("FAIL stream_valid[%0d] got %b want 1", i, outValid);
         end else begin
            expHead = expQ.pop_front();
            if ({outPC, outInstr} !== expHead) begin
               miscompares++; $display("FAIL stream[%0d] got %h/%h want %h/%h", i, outPC, outInstr, expHead[63:32], expHead[31:0]);
            end
         end
         $display("stream: pc=%h instr=%h", outPC, outInstr);
      end
   endtask

   task automatic test_stall();
      doReset(1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if (outValid !== 1'b1 || outPC !== 32'h0 || outInstr !== 32'h11) begin
            miscompares++; $display("FAIL stall_hold[%0d] got %b %h/%h want 1 0/11", i, outValid, outPC, outInstr);
         end
         $display("stall: pc=%h instr=%h fetchPC=%h", outPC, outInstr, fetchPC);
      end
      vectors++;
      if (fetchPC !== 32'h8) begin miscompares++; $display("FAIL stall_fetchpc got %h want 8", fetchPC); end
      vectors++;
      if (memAddress !== 7'd2) begin miscompares++; $display("FAIL stall_memaddr got %0d want 2", memAddress); end
      expQ.push_back({32'h0, 32'h11});
      expQ.push_back({32'h4, 32'h22});
      expQ.push_back({32'h8, 32'h33});
      outReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         vectors++;
         if (outValid !== 1'b1 || expQ.size() == 0) begin
            miscompares++; $display("FAIL release_valid[%0d] got %b want 1", i, outValid);
         end else begin
            expHead = expQ.pop_front();
            if ({outPC, outInstr} !== expHead) begin
               miscompares++; $display("FAIL release[%0d] got %h/%h want %h/%h", i, outPC, outInstr, expHead[63:32], expHead[31:0]);
            end
         end
         $display("release: pc=%h instr=%h", outPC, outInstr);
      end
   endtask

   task automatic test_redirect_wrap();
      doReset(1'b1);
      @(negedge clk);
      vectors++;
      if (outValid !== 1'b1 || outPC !== 32'h0 || outInstr !== 32'h11) begin
         miscompares++; $display("FAIL wrap_pre got %b %h/%h want 1 0/11", outValid, outPC, outInstr);
      end
      redirect = 1'b1;
      redirectPC = 32'h1FC;
      @(negedge clk);
      redirect = 1'b0;
      vectors++;
      if (outValid !== 1'b0) begin miscompares++; $display("FAIL wrap_flush got %b want 0", outValid); end
      vectors++;
      if (fetchPC !== 32'h1FC || memAddress !== 7'd127) begin
         miscompares++; $display("FAIL wrap_fetch got %h/%0d want 1fc/127", fetchPC, memAddress);
      end
      expQ.push_back({32'h1FC, 32'hAA});
      expQ.push_back({32'h200, 32'h11});
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         vectors++;
         if (outValid !== 1'b1 || expQ.size() == 0) begin
            miscompares++; $display("FAIL wrap_valid[%0d] got %b want 1", i, outValid);
         end else begin
            expHead = expQ.pop_front();
            if ({outPC, outInstr} !== expHead) begin
               miscompares++; $display("FAIL wrap[%0d] got %h/%h want %h/%h", i, outPC, outInstr, expHead[63:32], expHead[31:0]);
            end
         end
         $display("wrap: pc=%h instr=%h", outPC, outInstr);
      end
   endtask

   task automatic test_misaligned();
      doReset(1'b0);
      @(negedge clk);
      redirect = 1'b1;
      redirectPC = 32'h0000000B;
      @(negedge clk);
      redirect = 1'b0;
      outReady = 1'b1;
      vectors++;
      if (fetchPC !== 32'h8 || outValid !== 1'b0) begin
         miscompares++; $display("FAIL misaligned_fetch got %h valid %b want 8 valid 0", fetchPC, outValid);
      end
      expQ.push_back({32'h8, 32'h33});
      expQ.push_back({32'hC, 32'h0});
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         vectors++;
         if (outValid !== 1'b1 || expQ.size() == 0) begin
            miscompares++; $display("FAIL misaligned_valid[%0d] got %b want 1", i, outValid);
         end else begin
            expHead = expQ.pop_front();
            if ({outPC, outInstr} !== expHead) begin
               miscompares++; $display("FAIL misaligned[%0d] got %h/%h want %h/%h", i, outPC, outInstr, expHead[63:32], expHead[31:0]);
            end
         end
         $display("misaligned: pc=%h instr=%h", outPC, outInstr);
      end
   endtask

   task automatic test_async_reset();
      doReset(1'b1);
      @(negedge clk);
      @(negedge clk);
      #1 reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      vectors++;
      if (outValid !== 1'b0 || fetchPC !== 32'h0) begin
         miscompares++; $display("FAIL async_reset got valid %b fetchPC %h want 0/0", outValid, fetchPC);
      end
      vectors++;
      if (outPC !== 32'h0 || outInstr !== 32'h0) begin
         miscompares++; $display("FAIL async_reset_head got %h/%h want 0/0", outPC, outInstr);
      end
      $display("async reset: valid=%b fetchPC=%h", outValid, fetchPC);
      expQ.push_back({32'h0, 32'h11});
      expQ.push_back({32'h4, 32'h22});
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         vectors++;
         if (outValid !== 1'b1 || expQ.size() == 0) begin
            miscompares++; $display("FAIL restart_valid[%0d] got %b want 1", i, outValid);
         end else begin
            expHead = expQ.pop_front();
            if ({outPC, outInstr} !== expHead) begin
               miscompares++; $display("FAIL restart[%0d] got %h/%h want %h/%h", i, outPC, outInstr, expHead[63:32], expHead[31:0]);
            end
         end
         $display("restart: pc=%h instr=%h", outPC, outInstr);
      end
   endtask

   task automatic test_redirect_pop();
      doReset(1'b0);
      @(negedge clk);
      @(negedge clk);
      outReady = 1'b1;
      redirect = 1'b1;
      redirectPC = 32'h8;
      vectors++;
      if (outValid !== 1'b1 || outPC !== 32'h0 || outInstr !== 32'h11) begin
         miscompares++; $display("FAIL redirect_pop_head got %b %h/%h want 1 0/11", outValid, outPC, outInstr);
      end
      @(negedge clk);
      redirect = 1'b0;
      vectors++;
      if (outValid !== 1'b0) begin miscompares++; $display("FAIL redirect_pop_flush got %b want 0", outValid); end
      expQ.push_back({32'h8, 32'h33});
      expQ.push_back({32'hC, 32'h0});
      expQ.push_back({32'h10, 32'h0});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (outValid !== 1'b1 || expQ.size() == 0) begin
            miscompares++; $display("FAIL redirect_pop_valid[%0d] got %b want 1", i, outValid);
         end else begin
            expHead = expQ.pop_front();
            if ({outPC, outInstr} !== expHead) begin
               miscompares++; $display("FAIL redirect_pop[%0d] got %h/%h want %h/%h", i, outPC, outInstr, expHead[63:32], expHead[31:0]);
            end
         end
         $display("redirect+pop: pc=%h instr=%h", outPC, outInstr);
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = '0;
      mem[0]   = 32'h11;
      mem[1]   = 32'h22;
      mem[2]   = 32'h33;
      mem[127] = 32'hAA;
      test_reset();
      test_stream();
      test_stall();
      test_redirect_wrap();
      test_misaligned();
      test_async_reset();
      test_redirect_pop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
